ttl153_bus_arbiter: RTL and testbench

- Four-requester round-robin arbiter that drives the select pair and active-low strobe of a dual 4-to-1 data selector used as a shared bus source mux.
- Sequences break-before-make switching: the strobe is deasserted before the select changes, and the select settles one cycle before the strobe asserts.
- Sits between the requesting units (register file read port, PC, ALU out, immediate) and the selector pair that drives the internal bus.

---
 rtl/ttl153_bus_arbiter.sv | 101 ++++++++++
 tb/tb_ttl153_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttl153_bus_arbiter.sv
// Round-robin arbiter for four bus sources driving a dual 4-to-1 selector.
// Switching is break-before-make: the strobe drops before sel moves, and sel settles a cycle before the strobe.
module ttl153_bus_arbiter #(
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       enable_n,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam bit                TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LIM   = HOLD_W'(TIMEOUT_EN ? MAX_HOLD - 1 : 0);

    state_t            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic [1:0]        last_q;
    logic [1:0]        win_d;
    logic [3:0]        rot_req;

    // rot_req[gi] is the request sitting gi+1 places after the last winner
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot_req[gi] = req[last_q + 2'(gi + 1)];
    end

    always_comb begin
        win_d = last_q;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_d = last_q + 2'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            last_q   <= 2'd3;
            sel      <= 2'd0;
            enable_n <= 1'b1;
            grant    <= 4'b0000;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        sel     <= win_d;
                        busy    <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (req[sel]) begin
                        state_q  <= GRANT;
                        enable_n <= 1'b0;
                        grant    <= 4'b0001 << sel;
                        last_q   <= sel;
                        hold_q   <= '0;
                    end else begin
                        // requester gave up before the strobe: no grant, rotation untouched
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[sel] || (TIMEOUT_EN && hold_q == HOLD_LIM)) begin
                        state_q  <= IDLE;
                        enable_n <= 1'b1;
                        grant    <= 4'b0000;
                        busy     <= 1'b0;
                        timeout  <= req[sel];
                    end
                    if (hold_q != '1) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    enable_n <= 1'b1;
                    grant    <= 4'b0000;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttl153_bus_arbiter.sv
// Scoreboard bench: three arbiters (MAX_HOLD 0/4/8) share one request waveform; a
// waveform-level model predicts grant transactions and per-cycle sel/busy.
module tb_ttl153_bus_arbiter;

    localparam int NMAX = 400;

    typedef struct {
        int who;
        int st;
        int en;
        bit to;
    } txn_t;

    logic       clk;
    logic       reset_n;
    logic [3:0] req_x;

    logic [1:0] sel_w   [3];
    logic       en_n_w  [3];
    logic [3:0] grant_w [3];
    logic       busy_w  [3];
    logic       to_w    [3];

    ttl153_bus_arbiter #(.HOLD_W(4), .MAX_HOLD(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .req(req_x), .sel(sel_w[0]), .enable_n(en_n_w[0]),
        .grant(grant_w[0]), .busy(busy_w[0]), .timeout(to_w[0]));
    ttl153_bus_arbiter #(.HOLD_W(4), .MAX_HOLD(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req_x), .sel(sel_w[1]), .enable_n(en_n_w[1]),
        .grant(grant_w[1]), .busy(busy_w[1]), .timeout(to_w[1]));
    ttl153_bus_arbiter #(.HOLD_W(4), .MAX_HOLD(8)) dut2 (
        .clk(clk), .reset_n(reset_n), .req(req_x), .sel(sel_w[2]), .enable_n(en_n_w[2]),
        .grant(grant_w[2]), .busy(busy_w[2]), .timeout(to_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] stim   [0:NMAX];
    int         busy_e [3][0:NMAX];
    int         sel_e  [3][0:NMAX];
    txn_t       exp_q  [3][$];

    int n_err;
    int n_chk;
    int edge_no;
    bit mon_en;
    bit in_grant [3];
    int g_st     [3];
    int g_who    [3];
    txn_t t_m;

    function automatic int max_hold_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 4 : 8;
    endfunction

    task automatic clear_stim();
        for (int k = 0; k <= NMAX; k++) stim[k] = 4'b0000;
    endtask

    task automatic set_range(input int a, input int b, input logic [3:0] v);
        for (int k = a; k <= b; k++) stim[k] = v;
    endtask

    // Walks the whole request waveform: idle -> pick by rotation -> setup check -> hold until drop/limit.
    task automatic build_model(input int d, input int n);
        int   last, e, s, j, w, mh, cur_sel;
        bit   to;
        txn_t t;
        mh = max_hold_of(d);
        last = 3;
        cur_sel = 0;
        e = 1;
        for (int k = 0; k <= n; k++) begin
            busy_e[d][k] = 0;
            sel_e[d][k] = 0;
        end
        while (e <= n) begin
            if (stim[e] == 4'b0000) begin
                sel_e[d][e] = cur_sel;
                busy_e[d][e] = 0;
                e++;
            end else begin
                w = -1;
                for (int i = 1; i <= 4; i++) begin
                    if (w < 0 && stim[e][(last + i) % 4]) w = (last + i) % 4;
                end
                cur_sel = w;
                sel_e[d][e] = w;
                busy_e[d][e] = 1;
                s = e + 1;
                if (s > n) break;
                sel_e[d][s] = w;
                if (!stim[s][w]) begin
                    busy_e[d][s] = 0;
                    e = s + 1;
                end else begin
                    last = w;
                    busy_e[d][s] = 1;
                    j = s + 1;
                    to = 1'b0;
                    while (j <= n) begin
                        sel_e[d][j] = w;
                        if (!stim[j][w]) begin
                            busy_e[d][j] = 0;
                            break;
                        end
                        if (mh != 0 && j - s == mh) begin
                            to = 1'b1;
                            busy_e[d][j] = 0;
                            break;
                        end
                        busy_e[d][j] = 1;
                        j++;
                    end
                    if (j <= n) begin
                        t.who = w;
                        t.st = s;
                        t.en = j;
                        t.to = to;
                        exp_q[d].push_back(t);
                    end
                    e = j + 1;
                end
            end
        end
    endtask

    task automatic check_reset(input string nm);
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (sel_w[d] !== 2'd0 || en_n_w[d] !== 1'b1 || grant_w[d] !== 4'b0000 ||
                busy_w[d] !== 1'b0 || to_w[d] !== 1'b0) begin
                n_err++;
                $display("FAIL %s dut%0d got sel=%0d en_n=%b grant=%b busy=%b to=%b want sel=0 en_n=1 grant=0000 busy=0 to=0",
                         nm, d, sel_w[d], en_n_w[d], grant_w[d], busy_w[d], to_w[d]);
            end
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        req_x = 4'b0000;
        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            exp_q[d].delete();
            in_grant[d] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
    endtask

    task automatic run_phase(input string nm, input int n);
        for (int d = 0; d < 3; d++) build_model(d, n);
        $display("phase %s: %0d cycles, expected grants %0d/%0d/%0d", nm, n,
                 exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
        for (int k = 1; k <= n; k++) begin
            req_x = stim[k];
            @(posedge clk);
            edge_no = k;
            mon_en = 1'b1;
            @(negedge clk);
        end
        #1;
        mon_en = 1'b0;
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (exp_q[d].size() != 0 || in_grant[d]) begin
                n_err++;
                $display("FAIL drain %s dut%0d got %0d pending grants (open=%0d) want 0", nm, d,
                         exp_q[d].size(), in_grant[d]);
            end
        end
    endtask

    // Monitor: per-cycle sel/busy and invariants; one scoreboard pop per completed grant.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                n_chk++;
                if (int'(sel_w[d]) != sel_e[d][edge_no] || int'(busy_w[d]) != busy_e[d][edge_no]) begin
                    n_err++;
                    $display("FAIL state dut%0d edge=%0d got sel=%0d busy=%0d want sel=%0d busy=%0d",
                             d, edge_no, sel_w[d], busy_w[d], sel_e[d][edge_no], busy_e[d][edge_no]);
                end
                n_chk++;
                if ((en_n_w[d] !== (grant_w[d] == 4'b0000)) ||
                    (grant_w[d] != 4'b0000 && grant_w[d] != (4'b0001 << sel_w[d])) ||
                    (to_w[d] && !(in_grant[d] && grant_w[d] == 4'b0000))) begin
                    n_err++;
                    $display("FAIL invariant dut%0d edge=%0d got en_n=%b grant=%b sel=%0d to=%b want en_n low only with grant=1<<sel, timeout only at release",
                             d, edge_no, en_n_w[d], grant_w[d], sel_w[d], to_w[d]);
                end
                if (!in_grant[d] && grant_w[d] != 4'b0000) begin
                    in_grant[d] = 1'b1;
                    g_st[d] = edge_no;
                    g_who[d] = int'(sel_w[d]);
                end else if (in_grant[d] && grant_w[d] == 4'b0000) begin
                    in_grant[d] = 1'b0;
                    n_chk++;
                    if (exp_q[d].size() == 0) begin
                        n_err++;
                        $display("FAIL txn dut%0d got who=%0d st=%0d end=%0d to=%0d want no grant",
                                 d, g_who[d], g_st[d], edge_no, to_w[d]);
                    end else begin
                        t_m = exp_q[d].pop_front();
                        if (t_m.who != g_who[d] || t_m.st != g_st[d] || t_m.en != edge_no ||
                            t_m.to != to_w[d]) begin
                            n_err++;
                            $display("FAIL txn dut%0d got who=%0d st=%0d end=%0d to=%0d want who=%0d st=%0d end=%0d to=%0d",
                                     d, g_who[d], g_st[d], edge_no, to_w[d], t_m.who, t_m.st, t_m.en, t_m.to);
                        end else begin
                            $display("dut%0d grant who=%0d edges %0d..%0d timeout=%0d ok",
                                     d, g_who[d], g_st[d], edge_no, to_w[d]);
                        end
                    end
                end
            end
        end
    end

    task automatic build_random(input int n);
        logic [3:0] cur;
        cur = 4'b0000;
        clear_stim();
        for (int k = 1; k <= n - 8; k++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
            end
            stim[k] = cur;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_err = 0;
        n_chk = 0;
        edge_no = 0;
        mon_en = 1'b0;
        reset_n = 1'b0;
        req_x = 4'b0000;

        do_reset();
        clear_stim();
        set_range(1, 5, 4'b0001);
        run_phase("single", 14);

        // Each winner drops its request three cycles into the grant, back one cycle later.
        do_reset();
        clear_stim();
        set_range(1, 44, 4'b1111);
        for (int i = 0; i < 8; i++) stim[2 + 5 * i + 3][i % 4] = 1'b0;
        run_phase("rotation", 52);

        do_reset();
        clear_stim();
        set_range(1, 22, 4'b0100);
        run_phase("hold", 30);

        do_reset();
        clear_stim();
        set_range(1, 26, 4'b0101);
        run_phase("fairness", 34);

        do_reset();
        clear_stim();
        stim[1] = 4'b0010;
        set_range(5, 10, 4'b1010);
        run_phase("abort", 18);

        // Asynchronous reset while a grant is active.
        do_reset();
        req_x = 4'b1000;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (sel_w[d] !== 2'd3 || en_n_w[d] !== 1'b1) begin
                n_err++;
                $display("FAIL pre_sel dut%0d got sel=%0d en_n=%b want sel=3 en_n=1", d, sel_w[d], en_n_w[d]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (grant_w[d] !== 4'b1000 || en_n_w[d] !== 1'b0) begin
                n_err++;
                $display("FAIL pre_grant dut%0d got grant=%b en_n=%b want grant=1000 en_n=0", d, grant_w[d], en_n_w[d]);
            end
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("async_rst");
        do_reset();
        clear_stim();
        set_range(1, 4, 4'b1000);
        run_phase("after_reset", 12);

        do_reset();
        build_random(300);
        run_phase("random", 300);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
